// File: rtl/sc_backg_scroll_ctrl.sv
// Upstream sequencer for the background-type shift register: clear, load the
// start pattern, then rotate it one position per scroll tick with pause/stop.
module sc_backg_scroll_ctrl #(
  parameter int BACKGSCROLL_DATAWIDTH = 4,
  parameter int BACKGSCROLL_DIVWIDTH  = 26,
  parameter int BACKGSCROLL_BASEDIV   = 50000000,
  parameter int BACKGSCROLL_STEPWIDTH = 8
) (
  input  logic                             SC_BACKGSCROLL_CLOCK_50,
  input  logic                             SC_BACKGSCROLL_RESET_InLow,
  input  logic                             SC_BACKGSCROLL_start_InLow,
  input  logic                             SC_BACKGSCROLL_stop_InLow,
  input  logic                             SC_BACKGSCROLL_pause_InLow,
  input  logic                             SC_BACKGSCROLL_direction_In,
  input  logic [1:0]                       SC_BACKGSCROLL_speed_In,
  input  logic [BACKGSCROLL_DATAWIDTH-1:0] SC_BACKGSCROLL_pattern_InBUS,
  output logic                             SC_BACKGSCROLL_clear_OutLow,
  output logic                             SC_BACKGSCROLL_load_OutLow,
  output logic [1:0]                       SC_BACKGSCROLL_shiftselection_Out,
  output logic [BACKGSCROLL_DATAWIDTH-1:0] SC_BACKGSCROLL_data_OutBUS,
  output logic                             SC_BACKGSCROLL_running_Out,
  output logic [BACKGSCROLL_STEPWIDTH-1:0] SC_BACKGSCROLL_steps_OutBUS
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_t;

  localparam logic [BACKGSCROLL_DIVWIDTH-1:0] baseDiv =
    BACKGSCROLL_DIVWIDTH'(BACKGSCROLL_BASEDIV);

  state_t                            state, stateNext;
  logic [BACKGSCROLL_DIVWIDTH-1:0]   prescaler, prescalerNext;
  logic [BACKGSCROLL_DIVWIDTH-1:0]   divisor;
  logic [BACKGSCROLL_DIVWIDTH-1:0]   tickLimit;
  logic                              tickDue;
  logic [1:0]                        shiftCode;
  logic                              clearNext;
  logic                              loadNext;
  logic [1:0]                        shiftNext;
  logic [BACKGSCROLL_DATAWIDTH-1:0]  dataNext;
  logic                              runningNext;
  logic [BACKGSCROLL_STEPWIDTH-1:0]  stepsNext;

  // Compare with >= so a speed change that drops DIV below the running count
  // ticks on the next cycle instead of wrapping the prescaler.
  assign divisor   = baseDiv >> SC_BACKGSCROLL_speed_In;
  assign tickLimit = divisor - BACKGSCROLL_DIVWIDTH'(1);
  assign tickDue   = (prescaler >= tickLimit);
  assign shiftCode = SC_BACKGSCROLL_direction_In ? 2'b10 : 2'b01;

  always_ff @(posedge SC_BACKGSCROLL_CLOCK_50 or negedge SC_BACKGSCROLL_RESET_InLow) begin
    if (!SC_BACKGSCROLL_RESET_InLow) begin
      state                             <= ST_IDLE;
      prescaler                         <= '0;
      SC_BACKGSCROLL_clear_OutLow       <= 1'b1;
      SC_BACKGSCROLL_load_OutLow        <= 1'b1;
      SC_BACKGSCROLL_shiftselection_Out <= '0;
      SC_BACKGSCROLL_data_OutBUS        <= '0;
      SC_BACKGSCROLL_running_Out        <= 1'b0;
      SC_BACKGSCROLL_steps_OutBUS       <= '0;
    end else begin
      state                             <= stateNext;
      prescaler                         <= prescalerNext;
      SC_BACKGSCROLL_clear_OutLow       <= clearNext;
      SC_BACKGSCROLL_load_OutLow        <= loadNext;
      SC_BACKGSCROLL_shiftselection_Out <= shiftNext;
      SC_BACKGSCROLL_data_OutBUS        <= dataNext;
      SC_BACKGSCROLL_running_Out        <= runningNext;
      SC_BACKGSCROLL_steps_OutBUS       <= stepsNext;
    end
  end

  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    clearNext     = 1'b1;
    loadNext      = 1'b1;
    shiftNext     = '0;
    dataNext      = SC_BACKGSCROLL_data_OutBUS;
    runningNext   = SC_BACKGSCROLL_running_Out;
    stepsNext     = SC_BACKGSCROLL_steps_OutBUS;

    unique case (state)
      ST_IDLE: begin
        runningNext = 1'b0;
        if (!SC_BACKGSCROLL_start_InLow) begin
          stateNext = ST_CLEAR;
          dataNext  = SC_BACKGSCROLL_pattern_InBUS;
          clearNext = 1'b0;
        end
      end

      ST_CLEAR: begin
        if (!SC_BACKGSCROLL_stop_InLow) begin
          stateNext = ST_IDLE;
        end else begin
          stateNext = ST_LOAD;
          loadNext  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (!SC_BACKGSCROLL_stop_InLow) begin
          stateNext = ST_IDLE;
        end else begin
          stateNext     = ST_RUN;
          prescalerNext = '0;
          stepsNext     = '0;
          runningNext   = 1'b1;
        end
      end

      // Stop outranks pause, pause outranks a due tick; a tick that lands on a
      // pause is held at the limit and issued on the first cycle back in RUN.
      ST_RUN: begin
        if (!SC_BACKGSCROLL_stop_InLow) begin
          stateNext   = ST_IDLE;
          runningNext = 1'b0;
        end else if (!SC_BACKGSCROLL_pause_InLow) begin
          stateNext = ST_PAUSE;
        end else if (tickDue) begin
          prescalerNext = '0;
          shiftNext     = shiftCode;
          stepsNext     = SC_BACKGSCROLL_steps_OutBUS + BACKGSCROLL_STEPWIDTH'(1);
        end else begin
          prescalerNext = prescaler + BACKGSCROLL_DIVWIDTH'(1);
        end
      end

      ST_PAUSE: begin
        if (!SC_BACKGSCROLL_stop_InLow) begin
          stateNext   = ST_IDLE;
          runningNext = 1'b0;
        end else if (SC_BACKGSCROLL_pause_InLow) begin
          stateNext = ST_RUN;
        end
      end

      default: begin
        stateNext   = ST_IDLE;
        runningNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sc_backg_scroll_ctrl.sv
// Bench for sc_backg_scroll_ctrl: cycle model feeding an expectation queue,
// table-driven phases with end-of-phase checks, and hand-written corner cases.
module tb_sc_backg_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n, stop_n, pause_n, dir;
  logic [1:0] speed;
  logic [3:0] pattern;
  logic       clr_n, ld_n, running;
  logic [1:0] shsel;
  logic [3:0] dataOut;
  logic [7:0] steps;

  always #5 clk = ~clk;

  sc_backg_scroll_ctrl #(
    .BACKGSCROLL_DATAWIDTH(4),
    .BACKGSCROLL_DIVWIDTH (26),
    .BACKGSCROLL_BASEDIV  (8),
    .BACKGSCROLL_STEPWIDTH(8)
  ) dut (
    .SC_BACKGSCROLL_CLOCK_50          (clk),
    .SC_BACKGSCROLL_RESET_InLow       (rst_n),
    .SC_BACKGSCROLL_start_InLow       (start_n),
    .SC_BACKGSCROLL_stop_InLow        (stop_n),
    .SC_BACKGSCROLL_pause_InLow       (pause_n),
    .SC_BACKGSCROLL_direction_In      (dir),
    .SC_BACKGSCROLL_speed_In          (speed),
    .SC_BACKGSCROLL_pattern_InBUS     (pattern),
    .SC_BACKGSCROLL_clear_OutLow      (clr_n),
    .SC_BACKGSCROLL_load_OutLow       (ld_n),
    .SC_BACKGSCROLL_shiftselection_Out(shsel),
    .SC_BACKGSCROLL_data_OutBUS       (dataOut),
    .SC_BACKGSCROLL_running_Out       (running),
    .SC_BACKGSCROLL_steps_OutBUS      (steps)
  );

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;
  localparam int M_PAUSE = 4;
  localparam logic [16:0] RESET_PACK = {1'b1, 1'b1, 2'b00, 4'h0, 1'b0, 8'h00};

  int          nCompared   = 0;
  int          nMismatched = 0;

  int          mState;
  int          mPre;
  logic        mClr, mLd, mRun;
  logic [1:0]  mSh;
  logic [3:0]  mData;
  logic [7:0]  mSteps;
  logic [16:0] expQ[$];

  typedef struct {
    logic       startN, stopN, pauseN, dir;
    logic [1:0] speed;
    logic [3:0] pattern;
    int         cycles;
    logic       expClr, expLd;
    logic [1:0] expSh;
    logic       expRun;
    logic [7:0] expSteps;
    logic [3:0] expData;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [16:0] dutPack();
    return {clr_n, ld_n, shsel, dataOut, running, steps};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatched++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic modelReset();
    mState = M_IDLE;
    mPre   = 0;
    mClr   = 1'b1;
    mLd    = 1'b1;
    mSh    = 2'b00;
    mData  = 4'h0;
    mRun   = 1'b0;
    mSteps = 8'h00;
  endtask

  // Next registered outputs given the inputs currently being driven.
  task automatic modelStep();
    int div;
    if (!rst_n) begin
      modelReset();
      return;
    end
    div  = 8 >> speed;
    mClr = 1'b1;
    mLd  = 1'b1;
    mSh  = 2'b00;
    case (mState)
      M_IDLE:
        if (!start_n) begin
          mState = M_CLEAR;
          mData  = pattern;
          mClr   = 1'b0;
        end
      M_CLEAR:
        if (!stop_n) mState = M_IDLE;
        else begin
          mState = M_LOAD;
          mLd    = 1'b0;
        end
      M_LOAD:
        if (!stop_n) mState = M_IDLE;
        else begin
          mState = M_RUN;
          mPre   = 0;
          mSteps = 8'h00;
          mRun   = 1'b1;
        end
      M_RUN:
        if (!stop_n) begin
          mState = M_IDLE;
          mRun   = 1'b0;
        end else if (!pause_n) begin
          mState = M_PAUSE;
        end else if (mPre >= div - 1) begin
          mPre   = 0;
          mSh    = dir ? 2'b10 : 2'b01;
          mSteps = mSteps + 8'd1;
        end else begin
          mPre = mPre + 1;
        end
      M_PAUSE:
        if (!stop_n) begin
          mState = M_IDLE;
          mRun   = 1'b0;
        end else if (pause_n) begin
          mState = M_RUN;
        end
      default: mState = M_IDLE;
    endcase
  endtask

  // Entered and left at a falling edge; compares one registered update.
  task automatic runCycle(input string name);
    logic [16:0] exp;
    modelStep();
    expQ.push_back({mClr, mLd, mSh, mData, mRun, mSteps});
    @(posedge clk);
    #1;
    exp = expQ.pop_front();
    chk(name, 32'(dutPack()), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    vecs[0]  = '{1,1,1,0,2'd0,4'h3, 4, 1,1,2'd0,0,8'd0, 4'h0};
    vecs[1]  = '{0,1,1,0,2'd0,4'h3, 1, 0,1,2'd0,0,8'd0, 4'h3};
    vecs[2]  = '{1,1,1,0,2'd0,4'h3, 1, 1,0,2'd0,0,8'd0, 4'h3};
    vecs[3]  = '{1,1,1,0,2'd0,4'h3, 1, 1,1,2'd0,1,8'd0, 4'h3};
    vecs[4]  = '{1,1,1,0,2'd0,4'h3, 7, 1,1,2'd0,1,8'd0, 4'h3};
    vecs[5]  = '{1,1,1,0,2'd0,4'h3, 1, 1,1,2'd1,1,8'd1, 4'h3};
    vecs[6]  = '{1,1,1,0,2'd0,4'h3,16, 1,1,2'd1,1,8'd3, 4'h3};
    vecs[7]  = '{1,1,1,1,2'd2,4'h3, 9, 1,1,2'd0,1,8'd7, 4'h3};
    vecs[8]  = '{1,1,1,1,2'd2,4'h3, 1, 1,1,2'd2,1,8'd8, 4'h3};
    vecs[9]  = '{1,1,1,1,2'd3,4'h3, 6, 1,1,2'd2,1,8'd14,4'h3};
    vecs[10] = '{1,1,1,0,2'd0,4'h3, 5, 1,1,2'd0,1,8'd14,4'h3};
    vecs[11] = '{1,1,1,0,2'd2,4'h3, 1, 1,1,2'd1,1,8'd15,4'h3};
    vecs[12] = '{1,0,1,0,2'd0,4'h3, 1, 1,1,2'd0,0,8'd15,4'h3};
    vecs[13] = '{1,1,1,0,2'd0,4'h3, 3, 1,1,2'd0,0,8'd15,4'h3};
    vecs[14] = '{0,1,1,0,2'd0,4'hA, 1, 0,1,2'd0,0,8'd15,4'hA};
    vecs[15] = '{1,1,1,0,2'd0,4'hA, 2, 1,1,2'd0,1,8'd0, 4'hA};
    vecs[16] = '{1,0,1,0,2'd0,4'hA, 1, 1,1,2'd0,0,8'd0, 4'hA};
    vecs[17] = '{0,1,1,0,2'd0,4'h5, 1, 0,1,2'd0,0,8'd0, 4'h5};
    vecs[18] = '{1,0,1,0,2'd0,4'h5, 1, 1,1,2'd0,0,8'd0, 4'h5};
    vecs[19] = '{0,1,1,0,2'd0,4'h5, 1, 0,1,2'd0,0,8'd0, 4'h5};
    vecs[20] = '{1,1,1,0,2'd0,4'h5, 1, 1,0,2'd0,0,8'd0, 4'h5};
    vecs[21] = '{1,0,1,0,2'd0,4'h5, 1, 1,1,2'd0,0,8'd0, 4'h5};
    vecs[22] = '{0,1,1,0,2'd0,4'h3, 1, 0,1,2'd0,0,8'd0, 4'h3};
    vecs[23] = '{1,1,1,0,2'd0,4'h3, 2, 1,1,2'd0,1,8'd0, 4'h3};

    rst_n   = 1'b0;
    start_n = 1'b1;
    stop_n  = 1'b1;
    pause_n = 1'b1;
    dir     = 1'b0;
    speed   = 2'd0;
    pattern = 4'h0;
    modelReset();
    @(negedge clk);

    // Reset held three cycles, then released
    for (int i = 0; i < 3; i++) runCycle("resetHold");
    rst_n = 1'b1;
    chk("resetValues", 32'(dutPack()), 32'(RESET_PACK));

    for (int v = 0; v < 24; v++) begin
      start_n = vecs[v].startN;
      stop_n  = vecs[v].stopN;
      pause_n = vecs[v].pauseN;
      dir     = vecs[v].dir;
      speed   = vecs[v].speed;
      pattern = vecs[v].pattern;
      for (int c = 0; c < vecs[v].cycles; c++) runCycle($sformatf("vec%0d", v));
      chk($sformatf("vecEnd%0d", v), 32'(dutPack()),
          32'({vecs[v].expClr, vecs[v].expLd, vecs[v].expSh, vecs[v].expData,
               vecs[v].expRun, vecs[v].expSteps}));
    end

    // Pause while the prescaler sits at 5
    dir = 1'b0; speed = 2'd0; start_n = 1'b1; stop_n = 1'b1; pause_n = 1'b1;
    n = 0;
    while (mPre != 5 && n < 20) begin runCycle("toPre5"); n++; end
    if (mPre != 5) timeoutFail("toPre5");
    pause_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      runCycle("pause20");
      if (shsel != 2'b00) bad++;
    end
    chk("pauseNoShift", 32'(bad), 32'd0);
    chk("pauseStepsFrozen", 32'(steps), 32'd0);
    pause_n = 1'b1;
    runCycle("resume0");
    runCycle("resume1");
    chk("resume1Shift", 32'(shsel), 32'd0);
    runCycle("resume2");
    chk("resume2Shift", 32'(shsel), 32'd0);
    runCycle("resume3");
    chk("resume3Shift", 32'(shsel), 32'd1);
    chk("resume3Steps", 32'(steps), 32'd1);

    // Pause landing exactly on a due tick
    for (int i = 0; i < 7; i++) runCycle("toLimit");
    pause_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      runCycle("pauseOnTick");
      if (shsel != 2'b00) bad++;
    end
    chk("pauseOnTickNoShift", 32'(bad), 32'd0);
    pause_n = 1'b1;
    runCycle("tickResume0");
    chk("tickResume0Shift", 32'(shsel), 32'd0);
    runCycle("tickResume1");
    chk("tickResume1Shift", 32'(shsel), 32'd1);
    chk("tickResume1Steps", 32'(steps), 32'd2);

    // Start ignored in RUN, then stop and pause together
    start_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      runCycle("startInRun");
      if (clr_n != 1'b1) bad++;
    end
    chk("startIgnored", 32'(bad), 32'd0);
    start_n = 1'b1;
    stop_n  = 1'b0;
    pause_n = 1'b0;
    runCycle("stopPause");
    chk("stopPauseRunning", 32'(running), 32'd0);
    chk("stopPauseShift", 32'(shsel), 32'd0);
    stop_n  = 1'b1;
    pause_n = 1'b1;
    runCycle("idleAfterStop0");
    runCycle("idleAfterStop1");
    chk("idleNoClear", 32'({clr_n, ld_n}), 32'd3);

    // Step counter wrap at speed 2, right rotation
    start_n = 1'b0;
    runCycle("wrapStart");
    start_n = 1'b1;
    runCycle("wrapLoad");
    runCycle("wrapRunEntry");
    dir = 1'b1; speed = 2'd2;
    n = 0;
    while (mSteps != 8'd255 && n < 600) begin runCycle("toStep255"); n++; end
    if (mSteps != 8'd255) timeoutFail("toStep255");
    chk("steps255", 32'(steps), 32'd255);
    n = 0;
    while (mSteps != 8'd0 && n < 4) begin runCycle("toWrap"); n++; end
    if (mSteps != 8'd0) timeoutFail("toWrap");
    chk("wrapSteps", 32'(steps), 32'd0);
    chk("wrapShift", 32'(shsel), 32'd2);

    // Asynchronous reset between clock edges while running
    for (int i = 0; i < 3; i++) runCycle("preAsync");
    #2;
    rst_n = 1'b0;
    #1;
    chk("asyncReset", 32'(dutPack()), 32'(RESET_PACK));
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;
    runCycle("afterAsync0");
    runCycle("afterAsync1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
